mario_vram_cpu_if: RTL and testbench

//  CPU-side initiator for background VRAM and the vertical scroll latch. Decodes Z80 accesses
//  to 0x7400-0x77FF (VRAM) and 0x7D00 (scroll), holds the CPU in WAIT while the tile fetcher

---
 rtl/mario_vram_cpu_if.sv | 146 ++++++++++++++
 tb/tb_mario_vram_cpu_if.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_vram_cpu_if.sv
// rtl/mario_vram_cpu_if.sv - Z80-side initiator for background VRAM and the vertical scroll latch
module mario_vram_cpu_if #(
  parameter int STROBE_CYC = 4,
  parameter int VMOV_CYC   = 4
) (
  input  logic        I_CLK_24M,
  input  logic        I_RESET,
  input  logic [15:0] I_A,
  input  logic [7:0]  I_CPU_DO,
  input  logic        I_MREQn,
  input  logic        I_RFSHn,
  input  logic        I_RDn,
  input  logic        I_WRn,
  input  logic        I_VRAMBUSYn,
  input  logic [7:0]  I_VRAM_DB,
  output logic        O_WAITn,
  output logic [7:0]  O_CPU_DI,
  output logic [9:0]  O_VRAM_AB,
  output logic [7:0]  O_DB,
  output logic        O_VRAM_RDn,
  output logic        O_VRAM_WRn,
  output logic        O_VMOV
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_VPULSE = 3'd4
  } state_t;

  localparam logic [3:0] C_STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] C_VMOV_LOAD   = 4'(VMOV_CYC - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_req;
  logic        w_vsel;
  logic        w_ssel;
  logic        w_wait;
  logic        r_is_wr;
  logic [3:0]  r_cnt;
  logic [9:0]  r_vram_ab;
  logic [7:0]  r_db;
  logic [7:0]  r_cpu_di;
  logic        r_rdn;
  logic        r_wrn;
  logic        r_vmov;

  // Refresh cycles carry a row address on the bus and must never look like an access
  assign w_req  = !I_MREQn & I_RFSHn & (!I_RDn | !I_WRn);
  assign w_vsel = (I_A[15:10] == 6'b011101);
  assign w_ssel = (I_A == 16'h7D00) & !I_WRn;

  assign O_CPU_DI   = r_cpu_di;
  assign O_VRAM_AB  = r_vram_ab;
  assign O_DB       = r_db;
  assign O_VRAM_RDn = r_rdn;
  assign O_VRAM_WRn = r_wrn;
  assign O_VMOV     = r_vmov;

  // State register
  always_ff @(posedge I_CLK_24M or posedge I_RESET) begin
    if (I_RESET) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode; ARB checks the abort before the bus grant
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_vsel)      w_next = S_ARB;
        else if (w_req && w_ssel) w_next = S_VPULSE;
      end
      S_ARB: begin
        if (I_MREQn)          w_next = S_IDLE;
        else if (I_VRAMBUSYn) w_next = S_ACCESS;
      end
      S_ACCESS: if (r_cnt == 4'd0) w_next = S_HOLD;
      S_HOLD:   if (I_MREQn)       w_next = S_IDLE;
      S_VPULSE: if (r_cnt == 4'd0) w_next = S_HOLD;
      default:  w_next = S_IDLE;
    endcase
  end

  // WAIT is combinational so the CPU is stalled in the same T-state it asks; forced high in reset
  always_comb begin
    w_wait  = (w_req && w_vsel && (r_state != S_HOLD)) ||
              (r_state == S_ARB) || (r_state == S_ACCESS);
    O_WAITn = I_RESET || !w_wait;
  end

  // Registered datapath: address/data latch, strobes, pulse counter and read-data capture
  always_ff @(posedge I_CLK_24M or posedge I_RESET) begin
    if (I_RESET) begin
      r_is_wr   <= 1'b0;
      r_cnt     <= 4'd0;
      r_vram_ab <= 10'd0;
      r_db      <= 8'h00;
      r_cpu_di  <= 8'h00;
      r_rdn     <= 1'b1;
      r_wrn     <= 1'b1;
      r_vmov    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_vsel) begin
            // Address and data latched a full clock before any strobe can start
            r_vram_ab <= I_A[9:0];
            r_db      <= I_CPU_DO;
            r_is_wr   <= !I_WRn;
          end else if (w_req && w_ssel) begin
            r_db   <= I_CPU_DO;
            r_vmov <= 1'b1;
            r_cnt  <= C_VMOV_LOAD;
          end
        end
        S_ARB: begin
          if (!I_MREQn && I_VRAMBUSYn) begin
            if (r_is_wr) r_wrn <= 1'b0;
            else         r_rdn <= 1'b0;
            r_cnt <= C_STROBE_LOAD;
          end
        end
        S_ACCESS: begin
          // Busy is ignored here: once started, a strobe always runs its full length
          if (r_cnt == 4'd0) begin
            if (!r_is_wr) r_cpu_di <= I_VRAM_DB;
            r_rdn <= 1'b1;
            r_wrn <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_VPULSE: begin
          if (r_cnt == 4'd0) r_vmov <= 1'b0;
          else               r_cnt  <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mario_vram_cpu_if.sv
// tb/tb_mario_vram_cpu_if.sv - self-checking bench for mario_vram_cpu_if
module tb_mario_vram_cpu_if;

  localparam int STROBE = 4;
  localparam int VMOVC  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  cpu_do;
  logic        mreqn, rfshn, rdn, wrn, busyn;
  logic [7:0]  vram_db;
  logic        waitn;
  logic [7:0]  cpu_di;
  logic [9:0]  vram_ab;
  logic [7:0]  db;
  logic        vram_rdn, vram_wrn, vmov;

  mario_vram_cpu_if #(.STROBE_CYC(STROBE), .VMOV_CYC(VMOVC)) dut (
    .I_CLK_24M(clk), .I_RESET(rst), .I_A(a), .I_CPU_DO(cpu_do),
    .I_MREQn(mreqn), .I_RFSHn(rfshn), .I_RDn(rdn), .I_WRn(wrn),
    .I_VRAMBUSYn(busyn), .I_VRAM_DB(vram_db), .O_WAITn(waitn),
    .O_CPU_DI(cpu_di), .O_VRAM_AB(vram_ab), .O_DB(db),
    .O_VRAM_RDn(vram_rdn), .O_VRAM_WRn(vram_wrn), .O_VMOV(vmov)
  );

  always #5 clk = ~clk;

  // Device-side VRAM: unwritten cells return a fixed pattern
  logic [7:0] vram [0:1023];
  bit         vram_ok [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic [7:0] exp_cpu_di;

  function automatic logic [7:0] init_pat(input logic [9:0] ad);
    if (ad == 10'h3FF) return 8'hC3;
    return ad[7:0] ^ {ad[9:8], 6'h15};
  endfunction

  assign vram_db = vram_rdn ? 8'h00 : (vram_ok[vram_ab] ? vram[vram_ab] : init_pat(vram_ab));

  always @(posedge clk) begin
    if (!vram_wrn) begin
      vram[vram_ab]    <= db;
      vram_ok[vram_ab] <= 1'b1;
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    bit          is_wr;
    int          busy;
    bit          rfsh;
    int          e_wait;
    int          e_rd;
    int          e_wr;
    int          e_vmov;
  } vec_t;

  vec_t tbl [11];
  int   n_vec = 0;
  int   n_bad = 0;

  int         m_wait, m_rd, m_wr, m_vmov, m_both, m_first, m_unstable, m_post_strobe;
  logic [9:0] m_ab;
  logic [7:0] m_db, m_vdb;
  logic       m_post_waitn;
  bit         m_timeout;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle_bus();
    a = 16'h0000; cpu_do = 8'h00; mreqn = 1'b1; rfshn = 1'b1;
    rdn = 1'b1; wrn = 1'b1; busyn = 1'b1;
  endtask

  // Transaction-level expectations from the access rules
  function automatic vec_t model_expect(input vec_t v);
    vec_t r = v;
    bit in_vram = !v.rfsh && (v.addr >= 16'h7400) && (v.addr <= 16'h77FF);
    bit scroll  = !v.rfsh && v.is_wr && (v.addr == 16'h7D00);
    r.e_wait = in_vram ? STROBE + 2 + v.busy : 0;
    r.e_rd   = (in_vram && !v.is_wr) ? STROBE : 0;
    r.e_wr   = (in_vram && v.is_wr) ? STROBE : 0;
    r.e_vmov = scroll ? VMOVC : 0;
    return r;
  endfunction

  // One full CPU cycle; busy = number of arbitration samples that see the tile fetcher
  task automatic run_txn(input vec_t v);
    int k = 0;
    int hi_run = 0;
    m_wait = 0; m_rd = 0; m_wr = 0; m_vmov = 0; m_both = 0; m_first = -1;
    m_unstable = 0; m_post_strobe = 0; m_timeout = 1'b0; m_ab = '0; m_db = '0; m_vdb = '0;
    @(negedge clk);
    a = v.addr; cpu_do = v.data; mreqn = 1'b0; rfshn = !v.rfsh;
    rdn = v.is_wr; wrn = !v.is_wr; busyn = 1'b0;
    forever begin
      #2;
      if (!waitn) m_wait++;
      if (!vram_rdn) m_rd++;
      if (!vram_wrn) m_wr++;
      if (!vram_rdn && !vram_wrn) m_both++;
      if (vmov) begin m_vmov++; m_vdb = db; end
      if (!vram_rdn || !vram_wrn) begin
        if (m_first < 0) begin m_first = k; m_ab = vram_ab; m_db = db; end
        else if (vram_ab != m_ab || db != m_db) m_unstable++;
      end
      hi_run = waitn ? hi_run + 1 : 0;
      k++;
      if (hi_run >= 8) break;
      if (k >= 300) begin m_timeout = 1'b1; break; end
      @(negedge clk);
      busyn = (k > v.busy) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    idle_bus();
    #2;
    m_post_waitn = waitn;
    if (!vram_rdn || !vram_wrn) m_post_strobe++;
    @(negedge clk);
    #2;
    if (!vram_rdn || !vram_wrn) m_post_strobe++;
  endtask

  task automatic check_txn(input string tag, input vec_t v);
    bit in_vram = !v.rfsh && (v.addr >= 16'h7400) && (v.addr <= 16'h77FF);
    bit scroll  = !v.rfsh && v.is_wr && (v.addr == 16'h7D00);
    chk({tag, ".timeout"}, int'(m_timeout), 0);
    chk({tag, ".wait_low"}, m_wait, v.e_wait);
    chk({tag, ".rd_low"}, m_rd, v.e_rd);
    chk({tag, ".wr_low"}, m_wr, v.e_wr);
    chk({tag, ".vmov_high"}, m_vmov, v.e_vmov);
    chk({tag, ".rd_wr_overlap"}, m_both, 0);
    chk({tag, ".ab_db_unstable"}, m_unstable, 0);
    chk({tag, ".post_waitn"}, int'(m_post_waitn), 1);
    chk({tag, ".post_strobe"}, m_post_strobe, 0);
    chk({tag, ".strobe_start"}, m_first, in_vram ? v.busy + 2 : -1);
    if (in_vram) begin
      chk({tag, ".ab"}, int'(m_ab), int'(v.addr[9:0]));
      if (v.is_wr) begin
        chk({tag, ".db"}, int'(m_db), int'(v.data));
        ref_mem[v.addr[9:0]] = v.data;
      end else begin
        exp_cpu_di = ref_mem[v.addr[9:0]];
      end
    end
    if (scroll) chk({tag, ".vmov_db"}, int'(m_vdb), int'(v.data));
    chk({tag, ".cpu_di"}, int'(cpu_di), int'(exp_cpu_di));
  endtask

  initial begin
    vec_t v;
    int strobes;
    int wlow;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_pat(10'(i));
    exp_cpu_di = 8'h00;

    tbl[0]  = '{16'h7423, 8'h5A, 1'b1, 0,  1'b0, 6,  0, 4, 0};
    tbl[1]  = '{16'h77FF, 8'h00, 1'b0, 0,  1'b0, 6,  4, 0, 0};
    tbl[2]  = '{16'h7400, 8'h11, 1'b1, 50, 1'b0, 56, 0, 4, 0};
    tbl[3]  = '{16'h7D00, 8'h80, 1'b1, 0,  1'b0, 0,  0, 0, 4};
    tbl[4]  = '{16'h7D00, 8'h00, 1'b0, 0,  1'b0, 0,  0, 0, 0};
    tbl[5]  = '{16'h7400, 8'h99, 1'b1, 0,  1'b1, 0,  0, 0, 0};
    tbl[6]  = '{16'h1234, 8'h00, 1'b0, 0,  1'b0, 0,  0, 0, 0};
    tbl[7]  = '{16'h7800, 8'h44, 1'b1, 0,  1'b0, 0,  0, 0, 0};
    tbl[8]  = '{16'h73FF, 8'h44, 1'b1, 0,  1'b0, 0,  0, 0, 0};
    tbl[9]  = '{16'h7400, 8'h00, 1'b0, 3,  1'b0, 9,  4, 0, 0};
    tbl[10] = '{16'h7423, 8'h00, 1'b0, 0,  1'b0, 6,  4, 0, 0};

    rst = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    #2;
    chk("reset.waitn", int'(waitn), 1);
    chk("reset.rdn", int'(vram_rdn), 1);
    chk("reset.wrn", int'(vram_wrn), 1);
    chk("reset.vmov", int'(vmov), 0);
    chk("reset.ab", int'(vram_ab), 0);
    chk("reset.db", int'(db), 0);
    chk("reset.cpu_di", int'(cpu_di), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i]);
      check_txn($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Abort while waiting for the bus: no strobe, WAIT drops back
    @(negedge clk);
    a = 16'h7400; cpu_do = 8'hEE; mreqn = 1'b0; rdn = 1'b1; wrn = 1'b0; busyn = 1'b0;
    strobes = 0; wlow = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (!waitn) wlow++;
      if (!vram_rdn || !vram_wrn) strobes++;
      @(negedge clk);
    end
    idle_bus();
    busyn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (!vram_rdn || !vram_wrn) strobes++;
      @(negedge clk);
    end
    busyn = 1'b1;
    #2;
    chk("abort.wait_low", wlow, 4);
    chk("abort.strobes", strobes, 0);
    chk("abort.waitn", int'(waitn), 1);

    // Reset in the middle of a write strobe
    @(negedge clk);
    a = 16'h7500; cpu_do = 8'h77; mreqn = 1'b0; rdn = 1'b1; wrn = 1'b0; busyn = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_access.wrn_before", int'(vram_wrn), 0);
    rst = 1'b1;
    #1;
    chk("rst_access.wrn", int'(vram_wrn), 1);
    chk("rst_access.waitn", int'(waitn), 1);
    chk("rst_access.vmov", int'(vmov), 0);
    ref_mem[10'h100] = 8'h77;
    exp_cpu_di = 8'h00;
    @(negedge clk);
    idle_bus();
    rst = 1'b0;

    // Reset in the middle of a scroll pulse
    @(negedge clk);
    a = 16'h7D00; cpu_do = 8'h3C; mreqn = 1'b0; rdn = 1'b1; wrn = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_vpulse.vmov_before", int'(vmov), 1);
    rst = 1'b1;
    #1;
    chk("rst_vpulse.vmov", int'(vmov), 0);
    chk("rst_vpulse.waitn", int'(waitn), 1);
    @(negedge clk);
    idle_bus();
    rst = 1'b0;

    // Randomized accesses against the transaction model
    for (int i = 0; i < 60; i++) begin
      int cat = int'($urandom_range(0, 9));
      v.data  = 8'($urandom);
      v.is_wr = ($urandom_range(0, 1) == 1);
      v.busy  = int'($urandom_range(0, 6));
      v.rfsh  = 1'b0;
      if (cat <= 5 || cat == 9) v.addr = 16'h7400 + 16'($urandom_range(0, 1023));
      else if (cat == 6)        v.addr = 16'h7D00;
      else if (cat == 7)        v.addr = 16'($urandom);
      else begin
        v.addr = 16'h7400 + 16'($urandom_range(0, 1023));
        v.rfsh = 1'b1;
      end
      v = model_expect(v);
      run_txn(v);
      check_txn($sformatf("rnd[%0d]", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
